// File: rtl/imm_decode_stage_pkg.sv
// Shared RISC-V decode definitions: immediate formats and the opcodes that select them.
package imm_decode_stage_pkg;

    // Immediate format tag carried alongside each decoded entry
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Major opcodes (Inst[6:0]) recognised by the immediate decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: classifies the opcode and builds the
// sign-extended immediate for that format.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    imm_type_e   fmt;
    logic [31:0] raw;

    // Classify the opcode; register-register ops are legal but carry no immediate
    always_comb begin
        fmt     = IMM_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_IMM_32: fmt = IMM_I;
            OP_STORE:                            fmt = IMM_S;
            OP_BRANCH:                           fmt = IMM_B;
            OP_LUI, OP_AUIPC:                    fmt = IMM_U;
            OP_JAL:                              fmt = IMM_J;
            OP_REG, OP_REG_32:                   fmt = IMM_NONE;
            default:                             illegal = 1'b1;
        endcase
    end

    // Assemble the 32-bit immediate, already sign-extended from Inst[31]
    always_comb begin
        raw = 32'd0;
        case (fmt)
            IMM_I: raw = {{20{inst[31]}}, inst[31:20]};
            IMM_S: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: raw = {inst[31:12], 12'b0};
            IMM_J: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: raw = 32'd0;
        endcase
    end

    assign imm      = XLEN'($signed(raw));
    assign imm_type = fmt;

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes on acceptance and queues the results in a
// small FIFO so the consumer sees them in order, one cycle after acceptance.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Inst,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] Imm,
    output logic [2:0]      ImmType,
    output logic            Illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  imm_mem     [DEPTH];
    logic [2:0]       type_mem    [DEPTH];
    logic             illegal_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_type;
    logic             dec_illegal;
    logic             accept;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst     (Inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign InReady  = (count < CNT_W'(DEPTH));
    assign OutValid = (count != '0);
    assign accept   = InValid && InReady;
    assign pop      = OutValid && OutReady;

    // Occupancy and pointer bookkeeping; reset beats flush, flush drops any same-cycle accept
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= next_ptr(wr_ptr);
            if (pop)    rd_ptr <= next_ptr(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Store the decoded result at acceptance so the head never depends on Inst
    always_ff @(posedge Clk) begin
        if (accept && !Rst && !Flush) begin
            imm_mem[wr_ptr]     <= dec_imm;
            type_mem[wr_ptr]    <= dec_type;
            illegal_mem[wr_ptr] <= dec_illegal;
        end
    end

    // Present the head entry, forcing zeros whenever the queue is empty
    always_comb begin
        Imm     = '0;
        ImmType = 3'd0;
        Illegal = 1'b0;
        if (OutValid) begin
            Imm     = imm_mem[rd_ptr];
            ImmType = type_mem[rd_ptr];
            Illegal = illegal_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit/DEPTH=2 instance and a
// 64-bit/DEPTH=3 instance sharing clock, reset and flush.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  imm_type;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, illegal_w;
    logic [31:0] inst_w;
    logic [63:0] imm_w;
    logic [2:0]  imm_type_w;

    int compared   = 0;
    int mismatched = 0;

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .Clk(clk), .Rst(rst), .Flush(flush),
        .InValid(in_valid), .InReady(in_ready), .Inst(inst),
        .OutValid(out_valid), .OutReady(out_ready),
        .Imm(imm), .ImmType(imm_type), .Illegal(illegal)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(3)) dut_w (
        .Clk(clk), .Rst(rst), .Flush(flush),
        .InValid(in_valid_w), .InReady(in_ready_w), .Inst(inst_w),
        .OutValid(out_valid_w), .OutReady(out_ready_w),
        .Imm(imm_w), .ImmType(imm_type_w), .Illegal(illegal_w)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs reflect the new state
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Stall guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    logic [31:0] words   [5] = '{32'hfd010113, 32'h02812623, 32'h00f71863, 32'h0000b7b7, 32'h00c0006f};
    logic [31:0] exp_imm [5] = '{32'hFFFFFFD0, 32'h0000002C, 32'h00000010, 32'h0000B000, 32'h0000000C};
    logic [2:0]  exp_type[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [63:0] exp_w   [5] = '{64'hFFFFFFFFFFFFFFD0, 64'h2C, 64'h10, 64'hB000, 64'hC};

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; inst = '0; out_ready = 1'b0;
        in_valid_w = 1'b0; inst_w = '0; out_ready_w = 1'b0;

        // Reset state
        step(); step();
        checkOutput("rst_outvalid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_inready",  {63'd0, in_ready},  64'd1);
        checkOutput("rst_imm",      {32'd0, imm},       64'd0);
        checkOutput("rst_type",     {61'd0, imm_type},  64'd0);
        checkOutput("rst_illegal",  {63'd0, illegal},   64'd0);
        rst = 1'b0;

        // Back-to-back stream on both widths, one-cycle latency
        out_ready = 1'b1; out_ready_w = 1'b1;
        in_valid = 1'b1; in_valid_w = 1'b1;
        inst = words[0]; inst_w = words[0];
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("stream_valid%0d", i), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("stream_imm%0d", i),   {32'd0, imm}, {32'd0, exp_imm[i]});
            checkOutput($sformatf("stream_type%0d", i),  {61'd0, imm_type}, {61'd0, exp_type[i]});
            checkOutput($sformatf("stream64_imm%0d", i), imm_w, exp_w[i]);
            checkOutput($sformatf("stream64_type%0d", i), {61'd0, imm_type_w}, {61'd0, exp_type[i]});
            if (i < 4) begin
                inst = words[i+1]; inst_w = words[i+1];
            end
        end
        in_valid = 1'b0; in_valid_w = 1'b0;
        step();
        checkOutput("empty_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("empty_imm",   {32'd0, imm},       64'd0);

        // R-type and unknown opcode
        in_valid = 1'b1; inst = 32'h00000033;
        step();
        checkOutput("rtype_valid",   {63'd0, out_valid}, 64'd1);
        checkOutput("rtype_type",    {61'd0, imm_type},  64'd0);
        checkOutput("rtype_illegal", {63'd0, illegal},   64'd0);
        checkOutput("rtype_imm",     {32'd0, imm},       64'd0);
        inst = 32'h0000007F;
        step();
        checkOutput("bad_illegal", {63'd0, illegal},  64'd1);
        checkOutput("bad_type",    {61'd0, imm_type}, 64'd0);
        in_valid = 1'b0;
        step();

        // Backpressure: third word held until space frees
        out_ready = 1'b0; in_valid = 1'b1; inst = words[0];
        step();
        checkOutput("bp_inready1", {63'd0, in_ready}, 64'd1);
        inst = words[1];
        step();
        checkOutput("bp_full_inready", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_head0",        {32'd0, imm}, 64'hFFFFFFD0);
        inst = words[2];
        step();
        checkOutput("bp_hold_inready", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_hold_imm",     {32'd0, imm}, 64'hFFFFFFD0);
        checkOutput("bp_hold_type",    {61'd0, imm_type}, 64'd1);
        out_ready = 1'b1;
        step();
        checkOutput("bp_head1",    {32'd0, imm}, 64'h2C);
        checkOutput("bp_inready2", {63'd0, in_ready}, 64'd1);
        step();
        checkOutput("bp_head2",      {32'd0, imm}, 64'h10);
        checkOutput("bp_head2_type", {61'd0, imm_type}, 64'd3);
        in_valid = 1'b0;
        step();
        checkOutput("bp_drained", {63'd0, out_valid}, 64'd0);

        // DEPTH=3 fill from a wrapped pointer position, then drain in order
        out_ready_w = 1'b0; in_valid_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_w = words[i+1];
            step();
        end
        in_valid_w = 1'b0;
        checkOutput("w_full_inready", {63'd0, in_ready_w}, 64'd0);
        out_ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("w_drain%0d", i), imm_w, exp_w[i+1]);
            step();
        end
        checkOutput("w_drained", {63'd0, out_valid_w}, 64'd0);

        // Flush with a full buffer and a same-cycle push
        out_ready = 1'b0; in_valid = 1'b1; inst = words[0];
        step();
        inst = words[1];
        step();
        flush = 1'b1; inst = words[2];
        step();
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush_valid",   {63'd0, out_valid}, 64'd0);
        checkOutput("flush_inready", {63'd0, in_ready},  64'd1);
        checkOutput("flush_imm",     {32'd0, imm},       64'd0);
        step();
        checkOutput("flush_noghost", {63'd0, out_valid}, 64'd0);

        // Reset mid-stream with two entries buffered
        in_valid = 1'b1; inst = words[0];
        step();
        inst = words[3];
        step();
        in_valid = 1'b0;
        checkOutput("prerst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_valid",   {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_inready", {63'd0, in_ready},  64'd1);
        out_ready = 1'b1; in_valid = 1'b1; inst = 32'h02812623;
        step();
        in_valid = 1'b0;
        checkOutput("postrst_imm",  {32'd0, imm}, 64'h2C);
        checkOutput("postrst_type", {61'd0, imm_type}, 64'd2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
